// File: rtl/perceptron_host_master_if.sv
// UART-side byte channel between the perceptron host master and its TX/RX pair.
`timescale 1ns/1ps
interface perceptron_host_master_if;
    logic [7:0] tx_byte;
    logic       tx_send;
    logic       tx_busy;
    logic [7:0] rx_byte;
    logic       rx_ready;
    logic       rx_clear;

    modport master (
        output tx_byte, tx_send, rx_clear,
        input  tx_busy, rx_byte, rx_ready
    );

    modport slave (
        input  tx_byte, tx_send, rx_clear,
        output tx_busy, rx_byte, rx_ready
    );
endinterface

// File: rtl/perceptron_host_master.sv
// Host-side initiator of the perceptron UART protocol: sends weight/input writes
// and state reads, then validates the responder's ack, nack or data reply.
`timescale 1ns/1ps
module perceptron_host_master #(
    parameter int clock_frequency = 12000000,
    parameter int usart_baud_rate = 9600,
    parameter int timeout_bytes   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_wr_w,
    input  logic        cmd_wr_in,
    input  logic        cmd_rd,
    input  logic [15:0] weight1_in,
    input  logic [15:0] weight2_in,
    input  logic [15:0] data1_in,
    input  logic [15:0] data2_in,
    perceptron_host_master_if.master uart,
    output logic [15:0] rd_weight1,
    output logic [15:0] rd_weight2,
    output logic [15:0] rd_result,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  error_code
);

    localparam int TO_CYC = timeout_bytes * 10 * clock_frequency / usart_baud_rate;
    localparam int TW     = $clog2(TO_CYC + 1);
    localparam logic [TW-1:0] TO_TERM = TW'(TO_CYC - 1);

    localparam logic [7:0] OP_WR_W  = 8'd50;
    localparam logic [7:0] OP_WR_IN = 8'd51;
    localparam logic [7:0] OP_RD    = 8'd5;
    localparam logic [7:0] RSP_DATA = 8'd100;
    localparam logic [7:0] RSP_ACK  = 8'd101;
    localparam logic [7:0] RSP_NACK = 8'd102;

    localparam logic [1:0] EC_NACK = 2'd1;
    localparam logic [1:0] EC_BAD  = 2'd2;
    localparam logic [1:0] EC_TOUT = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_GUARD,
        S_WAIT_TX,
        S_NEXT_TX,
        S_WAIT_RX,
        S_REG_RX,
        S_DONE,
        S_ERR
    } state_t;

    state_t state, next;

    logic [31:0]   tx_buf;
    logic [7:0]    tx_byte_q;
    logic [7:0]    opcode;
    logic [2:0]    tx_cnt;
    logic [2:0]    rx_cnt;
    logic          op_rd;
    logic          hdr_seen;
    logic [39:0]   rx_sh;
    logic [TW-1:0] to_cnt;

    logic       accept;
    logic       ld_byte;
    logic       to_load;
    logic       shift_en;
    logic       hdr_set;
    logic       rd_upd;
    logic       err_set;
    logic [1:0] err_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next;
    end

    always_comb begin
        next     = state;
        accept   = 1'b0;
        ld_byte  = 1'b0;
        to_load  = 1'b0;
        shift_en = 1'b0;
        hdr_set  = 1'b0;
        rd_upd   = 1'b0;
        err_set  = 1'b0;
        err_val  = 2'd0;
        unique case (state)
            S_IDLE: begin
                if (cmd_wr_w || cmd_wr_in || cmd_rd) begin
                    accept = 1'b1;
                    next   = S_LOAD;
                end
            end
            S_LOAD: begin
                if (!uart.tx_busy) next = S_SEND;
            end
            S_SEND:  next = S_GUARD;
            S_GUARD: next = S_WAIT_TX;
            S_WAIT_TX: begin
                if (!uart.tx_busy) next = S_NEXT_TX;
            end
            S_NEXT_TX: begin
                if (tx_cnt == 3'd0) begin
                    next    = S_WAIT_RX;
                    to_load = 1'b1;
                end else if (!uart.tx_busy) begin
                    next    = S_SEND;
                    ld_byte = 1'b1;
                end
            end
            S_WAIT_RX: begin
                // A byte arriving on the terminal cycle still counts.
                if (uart.rx_ready) begin
                    next = S_REG_RX;
                end else if (to_cnt == TO_TERM) begin
                    next    = S_ERR;
                    err_set = 1'b1;
                    err_val = EC_TOUT;
                end
            end
            S_REG_RX: begin
                if (!op_rd) begin
                    if (uart.rx_byte == RSP_ACK) begin
                        next = S_DONE;
                    end else begin
                        next    = S_ERR;
                        err_set = 1'b1;
                        err_val = (uart.rx_byte == RSP_NACK) ? EC_NACK : EC_BAD;
                    end
                end else if (!hdr_seen) begin
                    if (uart.rx_byte == RSP_DATA) begin
                        next    = S_WAIT_RX;
                        hdr_set = 1'b1;
                        to_load = 1'b1;
                    end else begin
                        next    = S_ERR;
                        err_set = 1'b1;
                        err_val = EC_BAD;
                    end
                end else begin
                    shift_en = 1'b1;
                    if (rx_cnt == 3'd1) begin
                        next   = S_DONE;
                        rd_upd = 1'b1;
                    end else begin
                        next    = S_WAIT_RX;
                        to_load = 1'b1;
                    end
                end
            end
            S_DONE:  next = S_IDLE;
            S_ERR:   next = S_IDLE;
            default: next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_buf     <= '0;
            tx_byte_q  <= '0;
            opcode     <= '0;
            tx_cnt     <= '0;
            rx_cnt     <= '0;
            op_rd      <= 1'b0;
            hdr_seen   <= 1'b0;
            rx_sh      <= '0;
            to_cnt     <= '0;
            error_code <= '0;
            rd_weight1 <= '0;
            rd_weight2 <= '0;
            rd_result  <= '0;
        end else begin
            if (accept) begin
                error_code <= 2'd0;
                rx_cnt     <= 3'd6;
                hdr_seen   <= 1'b0;
                if (cmd_wr_w) begin
                    opcode <= OP_WR_W;
                    tx_buf <= {weight1_in, weight2_in};
                    tx_cnt <= 3'd4;
                    op_rd  <= 1'b0;
                end else if (cmd_wr_in) begin
                    opcode <= OP_WR_IN;
                    tx_buf <= {data1_in, data2_in};
                    tx_cnt <= 3'd4;
                    op_rd  <= 1'b0;
                end else begin
                    opcode <= OP_RD;
                    tx_buf <= '0;
                    tx_cnt <= 3'd0;
                    op_rd  <= 1'b1;
                end
            end
            if (state == S_LOAD) tx_byte_q <= opcode;
            if (ld_byte) begin
                tx_byte_q <= tx_buf[31:24];
                tx_buf    <= {tx_buf[23:0], 8'h00};
                tx_cnt    <= tx_cnt - 3'd1;
            end
            // The entry cycle counts as the first elapsed cycle.
            if (to_load) begin
                to_cnt <= TW'(1);
            end else if (state == S_WAIT_RX && to_cnt != TO_TERM) begin
                to_cnt <= to_cnt + TW'(1);
            end
            if (hdr_set) hdr_seen <= 1'b1;
            if (shift_en) begin
                rx_sh  <= {rx_sh[31:0], uart.rx_byte};
                rx_cnt <= rx_cnt - 3'd1;
            end
            if (rd_upd) begin
                rd_weight1 <= rx_sh[39:24];
                rd_weight2 <= rx_sh[23:8];
                rd_result  <= {rx_sh[7:0], uart.rx_byte};
            end
            if (err_set) error_code <= err_val;
        end
    end

    assign uart.tx_byte  = tx_byte_q;
    assign uart.tx_send  = (state == S_SEND);
    assign uart.rx_clear = (state == S_REG_RX) ||
                           (state == S_IDLE && uart.rx_ready);

    assign busy  = (state != S_IDLE);
    assign done  = (state == S_DONE);
    assign error = (state == S_ERR);

endmodule

// File: tb/tb_perceptron_host_master.sv
// Scoreboard bench for perceptron_host_master with a small UART TX/RX responder.
`timescale 1ns/1ps
module tb_perceptron_host_master;

    localparam int TO = 400;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_wr_w = 1'b0;
    logic        cmd_wr_in = 1'b0;
    logic        cmd_rd = 1'b0;
    logic [15:0] weight1_in = '0;
    logic [15:0] weight2_in = '0;
    logic [15:0] data1_in = '0;
    logic [15:0] data2_in = '0;
    logic [15:0] rd_weight1, rd_weight2, rd_result;
    logic        busy, done, error;
    logic [1:0]  error_code;

    logic [7:0] rx_b = '0;
    logic       rx_r = 1'b0;
    logic       force_busy = 1'b0;
    logic       busy_q;
    int         busy_left;

    perceptron_host_master_if u_if ();

    perceptron_host_master #(
        .clock_frequency(96000),
        .usart_baud_rate(9600),
        .timeout_bytes  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_wr_w  (cmd_wr_w),
        .cmd_wr_in (cmd_wr_in),
        .cmd_rd    (cmd_rd),
        .weight1_in(weight1_in),
        .weight2_in(weight2_in),
        .data1_in  (data1_in),
        .data2_in  (data2_in),
        .uart      (u_if),
        .rd_weight1(rd_weight1),
        .rd_weight2(rd_weight2),
        .rd_result (rd_result),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .error_code(error_code)
    );

    always #5 clk = ~clk;

    assign u_if.tx_busy  = busy_q | force_busy;
    assign u_if.rx_byte  = rx_b;
    assign u_if.rx_ready = rx_r;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_left <= 0;
            busy_q    <= 1'b0;
        end else begin
            busy_q    <= u_if.tx_send || (busy_left > 1);
            busy_left <= u_if.tx_send ? 3 : (busy_left > 0 ? busy_left - 1 : 0);
        end
    end

    typedef struct {
        int          kind;
        logic [1:0]  code;
        logic [15:0] w1;
        logic [15:0] w2;
        logic [15:0] res;
    } evt_t;

    logic [7:0] exp_tx[$];
    evt_t       exp_evt[$];

    int checks = 0;
    int errors = 0;
    int n_tx = 0;
    int n_evt = 0;
    int cyc = 0;
    int last_clr = 0;
    int err_cyc = 0;

    logic [15:0] m_w1 = '0, m_w2 = '0, m_res = '0;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        evt_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (u_if.rx_clear) last_clr = cyc;
                if (u_if.tx_send) begin
                    n_tx++;
                    if (exp_tx.size() == 0) begin
                        chk("tx_unexpected", 48'(u_if.tx_byte), 48'h1ff);
                    end else begin
                        chk("tx_byte", 48'(u_if.tx_byte), 48'(exp_tx.pop_front()));
                    end
                end
                if (done || error) begin
                    n_evt++;
                    err_cyc = cyc;
                    if (exp_evt.size() == 0) begin
                        chk("evt_unexpected", {46'd0, done, error}, 48'd0);
                    end else begin
                        e = exp_evt.pop_front();
                        chk("evt_kind", 48'(done ? 1 : 2), 48'(e.kind));
                        chk("evt_code", 48'(error_code), 48'(e.code));
                        chk("evt_w1", 48'(rd_weight1), 48'(e.w1));
                        chk("evt_w2", 48'(rd_weight2), 48'(e.w2));
                        chk("evt_res", 48'(rd_result), 48'(e.res));
                    end
                end
            end
        end
    end

    task automatic push_evt(input int kind, input logic [1:0] code);
        evt_t e;
        e.kind = kind;
        e.code = code;
        e.w1   = m_w1;
        e.w2   = m_w2;
        e.res  = m_res;
        exp_evt.push_back(e);
    endtask

    task automatic pulse(input logic ww, input logic wi, input logic rd);
        @(posedge clk);
        #1;
        cmd_wr_w  = ww;
        cmd_wr_in = wi;
        cmd_rd    = rd;
        @(posedge clk);
        #1;
        cmd_wr_w  = 1'b0;
        cmd_wr_in = 1'b0;
        cmd_rd    = 1'b0;
    endtask

    task automatic wait_tx(input int target);
        int k = 0;
        while (n_tx < target && k < 2000) begin
            @(posedge clk);
            k++;
        end
        chk("wait_tx", 48'(n_tx), 48'(target));
    endtask

    task automatic wait_evt(input int target);
        int k = 0;
        while (n_evt < target && k < 2000) begin
            @(posedge clk);
            k++;
        end
        chk("wait_evt", 48'(n_evt), 48'(target));
    endtask

    task automatic send_rx(input logic [7:0] b);
        int k = 0;
        @(posedge clk);
        #1;
        rx_b = b;
        rx_r = 1'b1;
        do begin
            @(negedge clk);
            k++;
        end while (!u_if.rx_clear && k < 2000);
        chk("rx_clear", 48'(u_if.rx_clear), 48'd1);
        @(posedge clk);
        #1;
        rx_r = 1'b0;
    endtask

    task automatic send_seq(input logic [7:0] b[]);
        foreach (b[i]) send_rx(b[i]);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", 48'(busy), 48'd0);
        chk("rst_done_err", {46'd0, done, error}, 48'd0);
        chk("rst_code", 48'(error_code), 48'd0);
        chk("rst_tx", {39'd0, u_if.tx_send, u_if.tx_byte}, 48'd0);
        chk("rst_rd", {rd_weight1, rd_weight2, rd_result}, 48'd0);

        // Weight write with opcode latency and ack
        exp_tx.push_back(8'd50);
        exp_tx.push_back(8'h12);
        exp_tx.push_back(8'h34);
        exp_tx.push_back(8'hAB);
        exp_tx.push_back(8'hCD);
        push_evt(1, 2'd0);
        weight1_in = 16'h1234;
        weight2_in = 16'hABCD;
        pulse(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("lat_busy", 48'(busy), 48'd1);
        chk("lat_nosend", 48'(u_if.tx_send), 48'd0);
        @(negedge clk);
        chk("lat_send", 48'(u_if.tx_send), 48'd1);
        wait_tx(5);
        send_rx(8'd101);
        wait_evt(1);
        chk("ww_code", 48'(error_code), 48'd0);

        // Successful read
        exp_tx.push_back(8'd5);
        m_w1 = 16'h0005;
        m_w2 = 16'hFFFE;
        m_res = 16'h0120;
        push_evt(1, 2'd0);
        pulse(1'b0, 1'b0, 1'b1);
        wait_tx(6);
        send_seq('{8'd100, 8'h00, 8'h05, 8'hFF, 8'hFE, 8'h01, 8'h20});
        wait_evt(2);

        // Input write, nack
        exp_tx.push_back(8'd51);
        exp_tx.push_back(8'h01);
        exp_tx.push_back(8'h02);
        exp_tx.push_back(8'h03);
        exp_tx.push_back(8'h04);
        push_evt(2, 2'd1);
        data1_in = 16'h0102;
        data2_in = 16'h0304;
        pulse(1'b0, 1'b1, 1'b0);
        wait_tx(11);
        send_rx(8'd102);
        wait_evt(3);
        repeat (4) @(negedge clk);
        chk("nack_code_held", 48'(error_code), 48'd1);

        // Read with bad header byte
        exp_tx.push_back(8'd5);
        push_evt(2, 2'd2);
        pulse(1'b0, 1'b0, 1'b1);
        wait_tx(12);
        send_rx(8'd99);
        wait_evt(4);

        // Read that stalls after three bytes
        exp_tx.push_back(8'd5);
        push_evt(2, 2'd3);
        pulse(1'b0, 1'b0, 1'b1);
        wait_tx(13);
        send_seq('{8'd100, 8'h11, 8'h22});
        wait_evt(5);
        chk("timeout_cycles", 48'(err_cyc - last_clr), 48'(TO));

        // Simultaneous commands and a command while busy
        exp_tx.push_back(8'd50);
        exp_tx.push_back(8'hBE);
        exp_tx.push_back(8'hEF);
        exp_tx.push_back(8'h00);
        exp_tx.push_back(8'h42);
        push_evt(1, 2'd0);
        weight1_in = 16'hBEEF;
        weight2_in = 16'h0042;
        pulse(1'b1, 1'b0, 1'b1);
        wait_tx(15);
        pulse(1'b0, 1'b0, 1'b1);
        wait_tx(18);
        send_rx(8'd101);
        wait_evt(6);
        repeat (20) @(posedge clk);
        chk("no_extra_tx", 48'(n_tx), 48'd18);
        send_rx(8'd101);
        repeat (10) @(negedge clk);
        chk("stray_no_evt", 48'(n_evt), 48'd6);
        chk("stray_idle", 48'(busy), 48'd0);

        // TX busy stall before the second byte
        exp_tx.push_back(8'd51);
        exp_tx.push_back(8'hCA);
        exp_tx.push_back(8'hFE);
        exp_tx.push_back(8'h00);
        exp_tx.push_back(8'h01);
        push_evt(1, 2'd0);
        data1_in = 16'hCAFE;
        data2_in = 16'h0001;
        pulse(1'b0, 1'b1, 1'b0);
        wait_tx(19);
        #1 force_busy = 1'b1;
        repeat (50) @(posedge clk);
        chk("stall_no_send", 48'(n_tx), 48'd19);
        #1 force_busy = 1'b0;
        wait_tx(23);
        send_rx(8'd101);
        wait_evt(7);

        // Reset while waiting for the reply
        exp_tx.push_back(8'd5);
        pulse(1'b0, 1'b0, 1'b1);
        wait_tx(24);
        repeat (5) @(posedge clk);
        chk("pre_rst_busy", 48'(busy), 48'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 48'(busy), 48'd0);
        chk("arst_tx", {39'd0, u_if.tx_send, u_if.tx_byte}, 48'd0);
        chk("arst_rx_clear", 48'(u_if.rx_clear), 48'd0);
        chk("arst_rd", {rd_weight1, rd_weight2, rd_result}, 48'd0);
        chk("arst_flags", {44'd0, done, error, error_code}, 48'd0);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        chk("post_rst_evt", 48'(n_evt), 48'd7);
        chk("queues_empty", 48'(exp_evt.size() + exp_tx.size()), 48'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
